// File: rtl/token_ring_arbiter_pkg.sv
// Shared types and one-hot helpers for the token ring arbiter.
// Helpers operate on a 32-bit container; callers zero-extend and truncate.
package token_ring_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_CIRC,
    ST_HOLD,
    ST_RECOVER
  } state_t;

  localparam int MAX_STATIONS = 32;

  // Rotate the low n bits of v left by one, bit n-1 wrapping to bit 0.
  function automatic logic [31:0] rotl1(input logic [31:0] v, input int n);
    logic [31:0] mask;
    mask = (n >= MAX_STATIONS) ? '1 : ((32'd1 << n) - 32'd1);
    return ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/token_ring_hold_ctr.sv
// Ownership-length counter: load to 1 when a grant starts, count up while held,
// flag when the holder has used its full allotment.
module token_ring_hold_ctr
  import token_ring_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic inc,
  output logic at_max
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= 8'd1;
    end else if (inc) begin
      count <= count + 8'd1;
    end
  end

  assign at_max = (count == 8'(HOLD_MAX));

endmodule

// File: rtl/token_ring_arbiter.sv
// N-station token ring: injects one token after reset, circulates it one station
// per cycle, grants bounded ownership to a requesting holder, and regenerates lost tokens.
module token_ring_arbiter
  import token_ring_arbiter_pkg::*;
#(
  parameter int N_STATIONS = 4,
  parameter int INIT_POS   = 0,
  parameter int HOLD_MAX   = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_STATIONS-1:0] req,
  input  logic [N_STATIONS-1:0] early_release,
  input  logic                  dbg_drop,
  output logic [N_STATIONS-1:0] grant,
  output logic [N_STATIONS-1:0] tok_vec,
  output logic                  tok_valid,
  output logic                  regen,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam logic [N_STATIONS-1:0] INIT_VEC =
    {{(N_STATIONS-1){1'b0}}, 1'b1} << INIT_POS;

  state_t                  state, state_n;
  logic [N_STATIONS-1:0]   tok_q, tok_n;
  logic [N_STATIONS-1:0]   grant_q, grant_n;
  logic                    regen_q, regen_n;
  logic [CNT_W-1:0]        err_q, err_n;
  logic [N_STATIONS-1:0]   tok_rot;
  logic                    holder_req, holder_rel;
  logic                    ctr_load, ctr_inc, ctr_at_max;

  assign tok_rot    = N_STATIONS'(rotl1(32'(tok_q), N_STATIONS));
  assign tok_valid  = is_onehot(32'(tok_q));
  assign holder_req = |(req & tok_q);
  assign holder_rel = |(early_release & tok_q);

  token_ring_hold_ctr #(
    .HOLD_MAX(HOLD_MAX)
  ) u_hold_ctr (
    .clk    (clk),
    .reset  (reset),
    .load   (ctr_load),
    .inc    (ctr_inc),
    .at_max (ctr_at_max)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_INIT;
      tok_q   <= '0;
      grant_q <= '0;
      regen_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state   <= state_n;
      tok_q   <= tok_n;
      grant_q <= grant_n;
      regen_q <= regen_n;
      err_q   <= err_n;
    end
  end

  // The health check outranks dbg_drop so a drop cannot mask an already-bad token.
  always_comb begin
    state_n  = state;
    tok_n    = tok_q;
    grant_n  = grant_q;
    regen_n  = 1'b0;
    err_n    = err_q;
    ctr_load = 1'b0;
    ctr_inc  = 1'b0;
    case (state)
      ST_INIT: begin
        tok_n   = INIT_VEC;
        grant_n = '0;
        state_n = ST_CIRC;
      end
      ST_CIRC: begin
        if (!tok_valid) begin
          grant_n = '0;
          state_n = ST_RECOVER;
        end else if (dbg_drop) begin
          tok_n   = '0;
          grant_n = '0;
        end else if (holder_req) begin
          grant_n  = tok_q;
          ctr_load = 1'b1;
          state_n  = ST_HOLD;
        end else begin
          tok_n = tok_rot;
        end
      end
      ST_HOLD: begin
        if (!tok_valid) begin
          grant_n = '0;
          state_n = ST_RECOVER;
        end else if (dbg_drop) begin
          tok_n   = '0;
          grant_n = '0;
          state_n = ST_CIRC;
        end else if (holder_rel || !holder_req || ctr_at_max) begin
          // Handing the token onward is what makes a persistent request wait a full lap.
          grant_n = '0;
          tok_n   = tok_rot;
          state_n = ST_CIRC;
        end else begin
          ctr_inc = 1'b1;
        end
      end
      ST_RECOVER: begin
        tok_n   = INIT_VEC;
        grant_n = '0;
        regen_n = 1'b1;
        if (err_q != '1) begin
          err_n = err_q + CNT_W'(1);
        end
        state_n = ST_CIRC;
      end
      default: begin
        grant_n = '0;
        state_n = ST_INIT;
      end
    endcase
  end

  assign grant   = grant_q;
  assign tok_vec = tok_q;
  assign regen   = regen_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_token_ring_arbiter.sv
// Bench for token_ring_arbiter: directed scenarios plus random traffic, all
// compared against a position/ownership model of the ring.
module tb_token_ring_arbiter;

  localparam int N        = 4;
  localparam int INIT_POS = 2;
  localparam int HOLD_MAX = 3;
  localparam int CNT_W    = 8;
  localparam int W        = 2 * N + 2 + CNT_W;
  localparam int ERR_MAX  = (1 << CNT_W) - 1;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]     req = '0;
  logic [N-1:0]     early_release = '0;
  logic             dbg_drop = 1'b0;
  logic [N-1:0]     grant;
  logic [N-1:0]     tok_vec;
  logic             tok_valid;
  logic             regen;
  logic [CNT_W-1:0] err_cnt;

  token_ring_arbiter #(
    .N_STATIONS(N),
    .INIT_POS  (INIT_POS),
    .HOLD_MAX  (HOLD_MAX),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .early_release(early_release),
    .dbg_drop     (dbg_drop),
    .grant        (grant),
    .tok_vec      (tok_vec),
    .tok_valid    (tok_valid),
    .regen        (regen),
    .err_cnt      (err_cnt)
  );

  logic [W-1:0] obs;
  assign obs = {tok_vec, grant, tok_valid, regen, err_cnt};

  // Scoreboard
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  // Reference model: where the token is (-1 = gone), whether its holder owns
  // the resource and for how long, and pending init/recovery work.
  int m_pos;
  bit m_grant;
  int m_len;
  bit m_init;
  bit m_recover;
  bit m_regen;
  int m_err;

  function automatic void model_reset();
    m_pos = -1; m_grant = 0; m_len = 0; m_init = 1;
    m_recover = 0; m_regen = 0; m_err = 0;
  endfunction

  function automatic logic [W-1:0] model_bus();
    logic [N-1:0] t;
    t = (m_pos < 0) ? '0 : (N'(1) << m_pos);
    return {t, (m_grant ? t : {N{1'b0}}), (m_pos >= 0), m_regen, CNT_W'(m_err)};
  endfunction

  function automatic void model_step(logic [N-1:0] r, logic [N-1:0] rl, logic d);
    m_regen = 0;
    if (m_init) begin
      m_pos = INIT_POS; m_init = 0;
    end else if (m_recover) begin
      m_pos = INIT_POS; m_regen = 1; m_recover = 0; m_grant = 0;
      if (m_err < ERR_MAX) m_err++;
    end else if (m_pos < 0) begin
      m_grant = 0; m_recover = 1;
    end else if (d) begin
      m_pos = -1; m_grant = 0;
    end else if (m_grant) begin
      if (rl[m_pos] || !r[m_pos] || m_len == HOLD_MAX) begin
        m_grant = 0; m_pos = (m_pos + 1) % N;
      end else begin
        m_len++;
      end
    end else if (r[m_pos]) begin
      m_grant = 1; m_len = 1;
    end else begin
      m_pos = (m_pos + 1) % N;
    end
  endfunction

  // Driver: apply inputs for one cycle, predict, then sample 1ns after the edge.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] rl, input logic d);
    req = r; early_release = rl; dbg_drop = d;
    @(posedge clk);
    model_step(r, rl, d);
    exp_q.push_back(model_bus());
    #1;
  endtask

  task automatic test_reset();
    logic [N-1:0] seq[4];
    seq = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin
      failures++; $display("FAIL reset_state obs=%h exp=%h", obs, {W{1'b0}});
    end
    reset = 1'b0;
    step('0, '0, 1'b0);
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL init_model obs=%h exp=%h", obs, exp_v);
    end
    checks++;
    if (tok_vec !== 4'b0100) begin
      failures++; $display("FAIL init_latency tok_vec=%b exp=0100", tok_vec);
    end
    for (int i = 0; i < 4; i++) begin
      step('0, '0, 1'b0);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL circ_model[%0d] obs=%h exp=%h", i, obs, exp_v);
      end
      checks++;
      if (tok_vec !== seq[i] || grant !== '0 || regen !== 1'b0) begin
        failures++;
        $display("FAIL circ_seq[%0d] tok=%b grant=%b regen=%b exp tok=%b", i, tok_vec, grant, regen, seq[i]);
      end
    end
  endtask

  task automatic test_hold_max();
    int run = 0;
    bit done = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0010, '0, 1'b0);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL hold_model[%0d] obs=%h exp=%h", i, obs, exp_v);
      end
      if (grant === 4'b0010) begin
        run++;
      end else if (run > 0 && !done) begin
        done = 1;
        checks++;
        if (run != HOLD_MAX || tok_vec !== 4'b0100) begin
          failures++; $display("FAIL hold_len run=%0d exp=%0d tok=%b exp=0100", run, HOLD_MAX, tok_vec);
        end
      end
    end
    checks++;
    if (!done) begin
      failures++; $display("FAIL hold_timeout grant never ended run=%0d exp=%0d", run, HOLD_MAX);
    end
  endtask

  task automatic test_release();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(4'b1000, '0, 1'b0);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL rel_wait_model[%0d] obs=%h exp=%h", i, obs, exp_v);
      end
      if (grant === 4'b1000) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL rel_timeout grant=%b exp=1000", grant);
    end
    step(4'b1000, '0, 1'b0);
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v || grant !== 4'b1000) begin
      failures++; $display("FAIL rel_second_cycle obs=%h exp=%h grant=%b", obs, exp_v, grant);
    end
    step(4'b1000, 4'b1000, 1'b0);
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v || grant !== 4'b0000 || tok_vec !== 4'b0001) begin
      failures++; $display("FAIL rel_handoff grant=%b tok=%b exp grant=0000 tok=0001", grant, tok_vec);
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 10 && m_pos != 0; i++) begin
      step('0, '0, 1'b0);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL drop_wait_model[%0d] obs=%h exp=%h", i, obs, exp_v);
      end
    end
    step('0, '0, 1'b1);
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v || tok_vec !== 4'b0000 || tok_valid !== 1'b0) begin
      failures++; $display("FAIL drop_clear tok=%b valid=%b exp tok=0000 valid=0", tok_vec, tok_valid);
    end
    step('0, '0, 1'b0);
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v || regen !== 1'b0) begin
      failures++; $display("FAIL drop_detect obs=%h exp=%h", obs, exp_v);
    end
    step('0, '0, 1'b0);
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v || tok_vec !== 4'b0100 || regen !== 1'b1 || err_cnt !== 8'd1) begin
      failures++; $display("FAIL drop_regen tok=%b regen=%b err=%0d exp tok=0100 regen=1 err=1", tok_vec, regen, err_cnt);
    end
    step('0, '0, 1'b0);
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v || regen !== 1'b0) begin
      failures++; $display("FAIL drop_regen_pulse regen=%b exp=0", regen);
    end
  endtask

  task automatic test_async_reset();
    bit held = 0;
    for (int i = 0; i < 10 && !held; i++) begin
      step(4'b1111, '0, 1'b0);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL ar_wait_model[%0d] obs=%h exp=%h", i, obs, exp_v);
      end
      if (grant !== '0) held = 1;
    end
    checks++;
    if (!held) begin
      failures++; $display("FAIL ar_timeout grant=%b exp nonzero", grant);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (grant !== '0 || tok_vec !== '0 || err_cnt !== '0) begin
      failures++; $display("FAIL ar_immediate grant=%b tok=%b err=%0d exp all zero", grant, tok_vec, err_cnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step('0, '0, 1'b0);
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v || tok_vec !== 4'b0100) begin
      failures++; $display("FAIL ar_reinject tok=%b exp=0100", tok_vec);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r, rl;
    logic d;
    for (int i = 0; i < 500; i++) begin
      r  = N'($urandom_range(0, 15));
      rl = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      d  = ($urandom_range(0, 29) == 0);
      step(r, rl, d);
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL rand_model[%0d] obs=%h exp=%h", i, obs, exp_v);
      end
      checks++;
      if ((grant & ~tok_vec) !== '0) begin
        failures++; $display("FAIL rand_grant_holder[%0d] grant=%b tok=%b", i, grant, tok_vec);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 3; k++) begin
        step('0, '0, (k == 0));
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin
          failures++; $display("FAIL sat_model[%0d.%0d] obs=%h exp=%h", i, k, obs, exp_v);
        end
      end
    end
    checks++;
    if (err_cnt !== 8'hFF) begin
      failures++; $display("FAIL sat_final err=%0d exp=255", err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_hold_max();
    test_release();
    test_drop();
    test_async_reset();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
